// File: rtl/bist_pkg.sv
// bist_pkg: FSM state encoding and default polynomial/seed constants shared by
// the bist_engine slice.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_SHIFT,
    ST_CAPTURE,
    ST_COMPARE,
    ST_DONE
  } bist_state_t;

  localparam logic [7:0] DEF_LFSR_POLY = 8'hB8;
  localparam logic [7:0] DEF_MISR_POLY = 8'hB8;
  localparam logic [7:0] DEF_LFSR_SEED = 8'h01;

endpackage

// File: rtl/bist_if.sv
// bist_if: BIST control/status and CUT data bundle. The master side is the
// host/CUT harness; the slave side is bist_engine.
interface bist_if #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned MISR_W = 8
);

  logic              bist_start;
  logic [N_IN-1:0]   func_in;
  logic [N_IN-1:0]   cut_in;
  logic [N_OUT-1:0]  cut_out;
  logic              scan_en;
  logic              scan_in;
  logic              bist_running;
  logic              bist_end;
  logic              pass_fail;
  logic [MISR_W-1:0] signature;

  modport master (
    output bist_start, func_in, cut_out,
    input  cut_in, scan_en, scan_in, bist_running, bist_end, pass_fail, signature
  );

  modport slave (
    input  bist_start, func_in, cut_out,
    output cut_in, scan_en, scan_in, bist_running, bist_end, pass_fail, signature
  );

endinterface

// File: rtl/bist_shift_reg.sv
// bist_shift_reg: generic left-shifting feedback register used as both the
// LFSR (xor_in tied 0) and the MISR (xor_in = CUT response).
module bist_shift_reg #(
  parameter int unsigned    W       = 8,
  parameter logic [W-1:0]   POLY    = 8'hB8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] xor_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= RST_VAL;
    else if (load)
      q <= load_val;
    else if (en)
      q <= {q[W-2:0], ^(q & POLY)} ^ xor_in;
  end

endmodule

// File: rtl/bist_engine.sv
// bist_engine: LFSR/MISR built-in self-test wrapper with pattern-count FSM,
// CUT input mux and golden-signature compare. Define BIST_SCAN_EN for scan sequencing.
module bist_engine
  import bist_pkg::*;
#(
  parameter int unsigned         N_IN       = 3,
  parameter int unsigned         N_OUT      = 3,
  parameter int unsigned         LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]   LFSR_POLY  = DEF_LFSR_POLY,
  parameter logic [LFSR_W-1:0]   LFSR_SEED  = DEF_LFSR_SEED,
  parameter int unsigned         MISR_W     = 8,
  parameter logic [MISR_W-1:0]   MISR_POLY  = DEF_MISR_POLY,
  parameter int unsigned         N_PATTERNS = 100,
  parameter logic [MISR_W-1:0]   GOLDEN_SIG = '0,
  parameter int unsigned         SCAN_LEN   = 8
) (
  input logic   CLK,
  input logic   RST,
  bist_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N_PATTERNS + 1);

  if (N_IN > LFSR_W || N_OUT > MISR_W || N_PATTERNS < 1 || SCAN_LEN < 1) begin : g_cfg_err
    $error("bist_engine: invalid parameter set");
  end

  bist_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [LFSR_W-1:0] lfsr;
  logic [MISR_W-1:0] misr;
  logic              pass_fail;
  logic              lfsr_load, lfsr_en, misr_load, misr_en;
  logic              cnt_clr, cnt_inc, pf_clr, pf_cmp;
  logic              running, done, scan_en_c;
  logic              unused_lfsr;

`ifdef BIST_SCAN_EN
  localparam int unsigned SH_W = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  logic [SH_W-1:0] sh_cnt;
  logic            sh_clr, sh_inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      sh_cnt <= '0;
    else if (sh_clr)
      sh_cnt <= '0;
    else if (sh_inc)
      sh_cnt <= sh_cnt + 1'b1;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    pf_clr    = 1'b0;
    pf_cmp    = 1'b0;
    running   = 1'b0;
    done      = 1'b0;
    scan_en_c = 1'b0;
`ifdef BIST_SCAN_EN
    sh_clr    = 1'b0;
    sh_inc    = 1'b0;
`endif
    case (state)
      ST_IDLE: if (bus.bist_start) state_n = ST_INIT;
      ST_INIT: begin
        running   = 1'b1;
        lfsr_load = 1'b1;
        misr_load = 1'b1;
        cnt_clr   = 1'b1;
        pf_clr    = 1'b1;
`ifdef BIST_SCAN_EN
        sh_clr    = 1'b1;
        state_n   = ST_SHIFT;
`else
        state_n   = ST_RUN;
`endif
      end
`ifdef BIST_SCAN_EN
      // cnt already equals N_PATTERNS during the final unload shift
      ST_SHIFT: begin
        running   = 1'b1;
        scan_en_c = 1'b1;
        lfsr_en   = 1'b1;
        misr_en   = 1'b1;
        sh_inc    = 1'b1;
        if (sh_cnt == SH_W'(SCAN_LEN - 1)) begin
          sh_clr  = 1'b1;
          state_n = (cnt == CNT_W'(N_PATTERNS)) ? ST_COMPARE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        running = 1'b1;
        misr_en = 1'b1;
        cnt_inc = 1'b1;
        state_n = ST_SHIFT;
      end
`else
      ST_RUN: begin
        running = 1'b1;
        lfsr_en = 1'b1;
        misr_en = 1'b1;
        cnt_inc = 1'b1;
        if (cnt == CNT_W'(N_PATTERNS - 1)) state_n = ST_COMPARE;
      end
`endif
      ST_COMPARE: begin
        running = 1'b1;
        pf_cmp  = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (!bus.bist_start) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      pass_fail <= 1'b0;
    end else begin
      if (cnt_clr)
        cnt <= '0;
      else if (cnt_inc)
        cnt <= cnt + 1'b1;
      if (pf_clr)
        pass_fail <= 1'b0;
      else if (pf_cmp)
        pass_fail <= (misr == GOLDEN_SIG);
    end
  end

  bist_shift_reg #(
    .W       (LFSR_W),
    .POLY    (LFSR_POLY),
    .RST_VAL (LFSR_SEED)
  ) u_lfsr (
    .clk      (CLK),
    .rst      (RST),
    .load     (lfsr_load),
    .load_val (LFSR_SEED),
    .en       (lfsr_en),
    .xor_in   ('0),
    .q        (lfsr)
  );

  bist_shift_reg #(
    .W       (MISR_W),
    .POLY    (MISR_POLY),
    .RST_VAL ('0)
  ) u_misr (
    .clk      (CLK),
    .rst      (RST),
    .load     (misr_load),
    .load_val ('0),
    .en       (misr_en),
    .xor_in   (MISR_W'(bus.cut_out)),
    .q        (misr)
  );

  assign unused_lfsr      = ^lfsr;
  assign bus.cut_in       = running ? lfsr[N_IN-1:0] : bus.func_in;
  assign bus.bist_running = running;
  assign bus.bist_end     = done;
  assign bus.pass_fail    = pass_fail;
  assign bus.signature    = misr;
  assign bus.scan_en      = scan_en_c;
`ifdef BIST_SCAN_EN
  assign bus.scan_in      = (state == ST_SHIFT) ? lfsr[0] : 1'b0;
`else
  assign bus.scan_in      = 1'b0;
`endif

endmodule

// File: tb/tb_bist_engine.sv
// tb_bist_engine: directed vector table plus hand-written multi-cycle sequences
// for bist_engine; scan expectations are selected by BIST_SCAN_EN.
module tb_bist_engine;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 CLK = ~CLK;

  bist_if #(.N_IN(3), .N_OUT(3), .MISR_W(4)) ifa ();
  bist_if #(.N_IN(3), .N_OUT(3), .MISR_W(8)) ifz ();
  bist_if #(.N_IN(3), .N_OUT(3), .MISR_W(8)) ifo ();
  bist_if #(.N_IN(3), .N_OUT(3), .MISR_W(8)) ifs ();

  bist_engine #(
    .N_IN(3), .N_OUT(3), .LFSR_W(4), .LFSR_POLY(4'b1001), .LFSR_SEED(4'b0001),
    .MISR_W(4), .MISR_POLY(4'b1001), .N_PATTERNS(4), .GOLDEN_SIG(4'b1010), .SCAN_LEN(3)
  ) dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));

  bist_engine #(.GOLDEN_SIG(8'h00)) dut_z (.CLK(CLK), .RST(RST), .bus(ifz.slave));
  bist_engine #(.GOLDEN_SIG(8'h01)) dut_o (.CLK(CLK), .RST(RST), .bus(ifo.slave));
  bist_engine #(.N_PATTERNS(2), .SCAN_LEN(3)) dut_s (.CLK(CLK), .RST(RST), .bus(ifs.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_a_end(input string name);
    int unsigned n = 0;
    while (ifa.bist_end !== 1'b1 && n < 300) begin
      @(posedge CLK); #1; n++;
    end
    check(name, ifa.bist_end, 1'b1);
  endtask

`ifndef BIST_SCAN_EN
  typedef struct {
    logic [2:0] func;
    logic       running;
    logic       done;
    logic       pf;
    logic [2:0] cut;
    logic [3:0] sig;
  } vec_t;
  vec_t vecs[8];
`endif

  initial begin
    int unsigned n;
    ifa.bist_start = 1'b0; ifa.func_in = 3'b101; ifa.cut_out = 3'b001;
    ifz.bist_start = 1'b0; ifz.func_in = 3'b000; ifz.cut_out = 3'b000;
    ifo.bist_start = 1'b0; ifo.func_in = 3'b000; ifo.cut_out = 3'b000;
    ifs.bist_start = 1'b0; ifs.func_in = 3'b000; ifs.cut_out = 3'b000;

    #12;
    check("rst_running", ifa.bist_running, 1'b0);
    check("rst_end",     ifa.bist_end,     1'b0);
    check("rst_pass",    ifa.pass_fail,    1'b0);
    check("rst_scan_en", ifa.scan_en,      1'b0);
    check("rst_scan_in", ifa.scan_in,      1'b0);
    check("rst_sig",     ifa.signature,    4'h0);
    check("rst_cut_in",  ifa.cut_in,       3'b101);
    @(negedge CLK) RST = 1'b0;

`ifndef BIST_SCAN_EN
    // rows are the state seen #1 after edge k, k = 0 being the start edge
    vecs[0] = '{3'b101, 1'b1, 1'b0, 1'b0, 3'b001, 4'h0};
    vecs[1] = '{3'b101, 1'b1, 1'b0, 1'b0, 3'b001, 4'h0};
    vecs[2] = '{3'b101, 1'b1, 1'b0, 1'b0, 3'b011, 4'h1};
    vecs[3] = '{3'b010, 1'b1, 1'b0, 1'b0, 3'b111, 4'h2};
    vecs[4] = '{3'b101, 1'b1, 1'b0, 1'b0, 3'b111, 4'h5};
    vecs[5] = '{3'b101, 1'b1, 1'b0, 1'b0, 3'b110, 4'hA};
    vecs[6] = '{3'b101, 1'b0, 1'b1, 1'b1, 3'b101, 4'hA};
    vecs[7] = '{3'b010, 1'b0, 1'b1, 1'b1, 3'b010, 4'hA};
    @(negedge CLK) ifa.bist_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifa.func_in = vecs[i].func;
      @(posedge CLK); #1;
      check($sformatf("v%0d_running", i), ifa.bist_running, vecs[i].running);
      check($sformatf("v%0d_end", i),     ifa.bist_end,     vecs[i].done);
      check($sformatf("v%0d_pass", i),    ifa.pass_fail,    vecs[i].pf);
      check($sformatf("v%0d_cut_in", i),  ifa.cut_in,       vecs[i].cut);
      check($sformatf("v%0d_sig", i),     ifa.signature,    vecs[i].sig);
      check($sformatf("v%0d_scan_en", i), ifa.scan_en,      1'b0);
    end
`else
    @(negedge CLK) ifa.bist_start = 1'b1;
    wait_a_end("scan_a_end");
    check("scan_a_sig",  ifa.signature, 4'hA);
    check("scan_a_pass", ifa.pass_fail, 1'b1);
`endif
    ifa.func_in = 3'b101;

    // bist_start held: must remain in DONE, no rerun
    repeat (3) @(posedge CLK);
    #1;
    check("hold_end",     ifa.bist_end,     1'b1);
    check("hold_running", ifa.bist_running, 1'b0);
    @(negedge CLK) ifa.bist_start = 1'b0;
    @(posedge CLK); #1;
    check("idle_end",    ifa.bist_end,  1'b0);
    check("idle_pass",   ifa.pass_fail, 1'b1);
    check("idle_cut_in", ifa.cut_in,    3'b101);

    @(negedge CLK) ifa.bist_start = 1'b1;
    @(posedge CLK); #1;
    check("rerun_init_pass", ifa.pass_fail, 1'b1);
    @(posedge CLK); #1;
    check("rerun_pass_clr", ifa.pass_fail, 1'b0);
    wait_a_end("rerun_end");
    check("rerun_sig",  ifa.signature, 4'hA);
    check("rerun_pass", ifa.pass_fail, 1'b1);

    // asynchronous reset in the middle of a run
    @(negedge CLK) ifa.bist_start = 1'b0;
    @(posedge CLK);
    @(negedge CLK) ifa.bist_start = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("mrst_running", ifa.bist_running, 1'b0);
    check("mrst_end",     ifa.bist_end,     1'b0);
    check("mrst_pass",    ifa.pass_fail,    1'b0);
    check("mrst_sig",     ifa.signature,    4'h0);
    check("mrst_cut_in",  ifa.cut_in,       3'b101);
    ifa.bist_start = 1'b0;
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    check("mrst_idle", ifa.bist_running, 1'b0);

    // all-zero response against two golden signatures
    @(negedge CLK) begin ifz.bist_start = 1'b1; ifo.bist_start = 1'b1; end
    n = 0;
    while (ifz.bist_end !== 1'b1 && n < 2000) begin
      @(posedge CLK); #1; n++;
    end
    check("zero_end",       ifz.bist_end,  1'b1);
    check("zero_sig",       ifz.signature, 8'h00);
    check("zero_pass",      ifz.pass_fail, 1'b1);
    check("zero_bad_end",   ifo.bist_end,  1'b1);
    check("zero_bad_pass",  ifo.pass_fail, 1'b0);

`ifdef BIST_SCAN_EN
    begin
      logic [11:1] exp_se;
      exp_se = 11'b111_0111_0111;
      @(negedge CLK) ifs.bist_start = 1'b1;
      @(posedge CLK); #1;
      check("scan_init_running", ifs.bist_running, 1'b1);
      check("scan_init_se",      ifs.scan_en,      1'b0);
      for (int k = 1; k <= 11; k++) begin
        @(posedge CLK); #1;
        check($sformatf("scan_se_k%0d", k), ifs.scan_en, exp_se[k]);
        if (k == 1) check("scan_in_k1", ifs.scan_in, 1'b1);
        if (k == 2) check("scan_in_k2", ifs.scan_in, 1'b0);
      end
      @(posedge CLK); #1;
      check("scan_cmp_running", ifs.bist_running, 1'b1);
      check("scan_cmp_end",     ifs.bist_end,     1'b0);
      @(posedge CLK); #1;
      check("scan_done_end",    ifs.bist_end,     1'b1);
      check("scan_done_pass",   ifs.pass_fail,    1'b1);
    end
`else
    @(negedge CLK) ifs.bist_start = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge CLK); #1;
      check($sformatf("s_scan_en_k%0d", k), ifs.scan_en, 1'b0);
      if (k == 3) begin
        check("s_k3_end",     ifs.bist_end,     1'b0);
        check("s_k3_running", ifs.bist_running, 1'b1);
      end
    end
    check("s_k4_end",  ifs.bist_end,  1'b1);
    check("s_k4_pass", ifs.pass_fail, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
